mac_result_drain: RTL and testbench
===================================

Name: mac_result_drain

Overview:
- Sits directly downstream of the MAC array and consumes its per-lane accumulator outputs once a tile's accumulation is complete.
- On a capture request it snapshots every lane's accumulator in one cycle, freeing the array for the next tile.
- It then requantizes each lane (round, arithmetic shift, optional ReLU, saturate) and drains the lanes one per handshake on a valid/ready stream toward the output buffer.

Parameters:
- ARRAY_SIZE, 2, number of MAC lanes captured and drained.
- ACCUMULATOR_DATA_WIDTH, 16, signed accumulator width per lane.
- OUTPUT_DATA_WIDTH, 8, signed requantized output width.
- SHIFT_WIDTH, 4, width of the right-shift amount.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- capture_valid  input  1  controller requests a snapshot of the accumulators.
- capture_ready  output  1  high when a snapshot can be accepted.
- accumulator  input  ARRAY_SIZE x ACCUMULATOR_DATA_WIDTH  per-lane signed accumulators from the MAC array.
- shift_amt  input  SHIFT_WIDTH  right-shift amount, sampled at capture.
- relu_en  input  1  clamps negative results to 0; sampled at capture.
- out_valid  output  1  out_data holds a valid lane result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  OUTPUT_DATA_WIDTH  signed requantized result.
- out_index  output  clog2(ARRAY_SIZE), min 1  lane number of out_data.
- out_last  output  1  high with the final lane of a snapshot.
- busy  output  1  high while a drain is in progress.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; out_valid, out_last and busy = 0; out_index = 0; capture_ready = 1.
  - Snapshot registers are cleared to 0.
- The state machine has two states, IDLE and DRAIN. capture_ready = (state == IDLE); busy = (state == DRAIN).
- IDLE:
  - When capture_valid & capture_ready at edge N, all ARRAY_SIZE accumulators, shift_amt and relu_en are registered.
  - At the same edge, idx is set to 0 and the state moves to DRAIN.
  - out_valid rises in cycle N+1, so the first result has a one-cycle latency.
- DRAIN:
  - out_valid = 1 and out_index = idx.
  - out_last = (idx == ARRAY_SIZE-1).
  - On out_valid & out_ready: if out_last, go to IDLE and reset idx to 0; otherwise idx increments.
  - With out_ready held high, lanes drain one per cycle.
  - capture_valid is ignored in DRAIN. The accumulator input may change freely because the snapshot is held.
- Backpressure: while out_valid & !out_ready, out_data, out_index and out_last stay stable and idx does not advance.
- A new capture is accepted no earlier than the cycle after the last handshake. Back-to-back snapshots therefore cost 1 idle cycle.
- Requantization of lane idx uses the registered values and is computed combinationally from registers only:
  1. Round half up: if s > 0, r = acc + (1 << (s-1)), computed at ACCUMULATOR_DATA_WIDTH+1 bits signed so there is no overflow; if s = 0, r = acc.
  2. Arithmetic shift: q = r >>> s, sign-extended.
  3. ReLU: if relu_en and q < 0, q = 0.
  4. Saturate: clamp q to [-2^(OUTPUT_DATA_WIDTH-1), 2^(OUTPUT_DATA_WIDTH-1)-1], i.e. [-128, 127] at the defaults.
- Reset asserted mid-drain: the machine returns to IDLE immediately. Remaining lanes are discarded and no out_last is emitted.
- out_valid is never asserted in IDLE.

Test Plan:
- Basic drain, out_ready = 1:
  - Stimulus: acc = {lane0: 256, lane1: -256}, shift = 2, relu = 0, capture at edge N.
  - Response: out_valid in cycles N+1 and N+2 with data 64 then -64; index 0 then 1; out_last only with lane 1; capture_ready = 0 in N+1..N+2 and 1 in N+3.
- Saturation:
  - Stimulus: acc = {1000, -1000}, shift = 0.
  - Response: out_data 127, then -128.
- Rounding:
  - Stimulus: acc = {6, -6}, shift = 2.
  - Response: 2, then -1.
  - Stimulus: acc = {5, 32767}, shift = 1.
  - Response: 3, then 127 (no wrap in the rounding add).
- ReLU:
  - Stimulus: acc = {-256, 300}, shift = 2, relu = 1.
  - Response: 0, then 75.
- Backpressure and snapshot isolation:
  - Stimulus: hold out_ready = 0 for 3 cycles with lane 0 valid, and change the accumulator input and capture_valid during that window.
  - Response: lane 0 data and index stay stable, capture is not accepted, and lane 1 reflects the original snapshot after out_ready rises.
- Reset mid-drain:
  - Stimulus: assert rst_n = 0 asynchronously after the lane 0 handshake.
  - Response: out_valid = 0 immediately, capture_ready = 1 after release, and the next capture drains from lane 0.

Source files
------------

// File: rtl/mac_result_drain.sv
// mac_result_drain: snapshots the MAC array's per-lane accumulators in one
// cycle. It then requantizes each lane (round half up, arithmetic shift,
// optional ReLU, saturate) and streams the lanes out one per valid/ready
// handshake.
module mac_result_drain #(
  parameter int ARRAY_SIZE             = 2,
  parameter int ACCUMULATOR_DATA_WIDTH = 16,
  parameter int OUTPUT_DATA_WIDTH      = 8,
  parameter int SHIFT_WIDTH            = 4,
  localparam int IDX_WIDTH = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
  input  logic                                                clk_i,
  input  logic                                                rst_ni,
  input  logic                                                capture_valid_i,
  output logic                                                capture_ready_o,
  input  logic [ARRAY_SIZE-1:0][ACCUMULATOR_DATA_WIDTH-1:0]   accumulator_i,
  input  logic [SHIFT_WIDTH-1:0]                              shift_amt_i,
  input  logic                                                relu_en_i,
  output logic                                                out_valid_o,
  input  logic                                                out_ready_i,
  output logic [OUTPUT_DATA_WIDTH-1:0]                        out_data_o,
  output logic [IDX_WIDTH-1:0]                                out_index_o,
  output logic                                                out_last_o,
  output logic                                                busy_o
);

  localparam int ACC_W = ACCUMULATOR_DATA_WIDTH;
  localparam int OUT_W = OUTPUT_DATA_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(ARRAY_SIZE - 1);
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(1 << (OUT_W-1)));

  typedef enum logic {
    IDLE,
    DRAIN
  } state_e;

  state_e                              state_q, state_d;
  logic [IDX_WIDTH-1:0]                idx_q, idx_d;
  logic                                out_valid_q, out_valid_d;
  logic                                out_last_q, out_last_d;
  logic                                busy_q, busy_d;
  logic                                capture_ready_q, capture_ready_d;
  logic [ARRAY_SIZE-1:0][ACC_W-1:0]    snap_q, snap_d;
  logic [SHIFT_WIDTH-1:0]              shift_q, shift_d;
  logic                                relu_q, relu_d;

  logic signed [ACC_W-1:0]             lane_acc;
  logic        [ACC_W:0]               round_inc;
  logic signed [ACC_W:0]               rounded;
  logic signed [ACC_W:0]               shifted;
  logic signed [ACC_W:0]               clamped;

  // Next-state logic: capture in IDLE, advance one lane per handshake in DRAIN.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    out_valid_d     = out_valid_q;
    out_last_d      = out_last_q;
    busy_d          = busy_q;
    capture_ready_d = capture_ready_q;
    snap_d          = snap_q;
    shift_d         = shift_q;
    relu_d          = relu_q;
    unique case (state_q)
      IDLE: begin
        if (capture_valid_i) begin
          state_d         = DRAIN;
          idx_d           = '0;
          snap_d          = accumulator_i;
          shift_d         = shift_amt_i;
          relu_d          = relu_en_i;
          out_valid_d     = 1'b1;
          out_last_d      = (LAST_IDX == '0);
          busy_d          = 1'b1;
          capture_ready_d = 1'b0;
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready_i) begin
          if (out_last_q) begin
            state_d         = IDLE;
            idx_d           = '0;
            out_valid_d     = 1'b0;
            out_last_d      = 1'b0;
            busy_d          = 1'b0;
            capture_ready_d = 1'b1;
          end else begin
            idx_d      = idx_q + IDX_WIDTH'(1);
            out_last_d = ((idx_q + IDX_WIDTH'(1)) == LAST_IDX);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, registered outputs and the held snapshot; reset drops any drain in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      out_valid_q     <= 1'b0;
      out_last_q      <= 1'b0;
      busy_q          <= 1'b0;
      capture_ready_q <= 1'b1;
      snap_q          <= '0;
      shift_q         <= '0;
      relu_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      out_valid_q     <= out_valid_d;
      out_last_q      <= out_last_d;
      busy_q          <= busy_d;
      capture_ready_q <= capture_ready_d;
      snap_q          <= snap_d;
      shift_q         <= shift_d;
      relu_q          <= relu_d;
    end
  end

  // Requantize the current lane from registers only; one extra bit keeps the rounding add from wrapping.
  always_comb begin
    lane_acc  = snap_q[idx_q];
    round_inc = '0;
    if (shift_q != '0) begin
      round_inc = (ACC_W+1)'(1) << (shift_q - SHIFT_WIDTH'(1));
    end
    rounded = $signed({lane_acc[ACC_W-1], lane_acc}) + $signed(round_inc);
    shifted = rounded >>> shift_q;
    clamped = shifted;
    if (relu_q && shifted[ACC_W]) begin
      clamped = '0;
    end
    if (clamped > SAT_MAX) begin
      clamped = SAT_MAX;
    end else if (clamped < SAT_MIN) begin
      clamped = SAT_MIN;
    end
  end

  assign out_data_o      = clamped[OUT_W-1:0];
  assign out_index_o     = idx_q;
  assign out_valid_o     = out_valid_q;
  assign out_last_o      = out_last_q;
  assign busy_o          = busy_q;
  assign capture_ready_o = capture_ready_q;

endmodule

// File: tb/tb_mac_result_drain.sv
// tb_mac_result_drain: directed table vectors, hand-written backpressure and
// reset corner cases, and randomized snapshots checked against an arithmetic
// reference model of the requantization.
module tb_mac_result_drain;

  logic              clk;
  logic              rst_n;
  logic              capture_valid;
  logic              capture_ready;
  logic [1:0][15:0]  accumulator;
  logic [3:0]        shift_amt;
  logic              relu_en;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic [0:0]        out_index;
  logic              out_last;
  logic              busy;

  int passCount  = 0;
  int checkCount = 0;

  typedef struct {
    int acc0;
    int acc1;
    int shift;
    bit relu;
    int exp0;
    int exp1;
  } vector_t;

  vector_t vectors[6];

  mac_result_drain dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .capture_valid_i (capture_valid),
    .capture_ready_o (capture_ready),
    .accumulator_i   (accumulator),
    .shift_amt_i     (shift_amt),
    .relu_en_i       (relu_en),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_data_o      (out_data),
    .out_index_o     (out_index),
    .out_last_o      (out_last),
    .busy_o          (busy)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference requantization: floor division by 2^shift after adding half, then ReLU and clamp.
  function automatic int refQuant(input int acc, input int sh, input bit relu);
    longint v;
    longint d;
    longint q;
    d = longint'(1) << sh;
    v = acc;
    if (sh > 0) v = v + d / 2;
    q = v / d;
    if (v < 0 && (v % d) != 0) q = q - 1;
    if (relu && q < 0) q = 0;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return int'(q);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One complete snapshot: capture, then drain both lanes with optional stall cycles per lane.
  task automatic applyStimulus(input int a0, input int a1, input int sh, input bit relu,
                               input int e0, input int e1, input int st0, input int st1,
                               input string tag);
    int waited;
    int exps[2];
    int stalls[2];
    exps[0]   = e0;
    exps[1]   = e1;
    stalls[0] = st0;
    stalls[1] = st1;
    waited    = 0;
    while (!capture_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput({tag, " capture_ready before capture"}, int'(capture_ready), 1);
    capture_valid  = 1'b1;
    accumulator[0] = a0[15:0];
    accumulator[1] = a1[15:0];
    shift_amt      = sh[3:0];
    relu_en        = relu;
    @(posedge clk); #1;
    capture_valid = 1'b0;
    accumulator   = {16'($urandom), 16'($urandom)};
    shift_amt     = 4'($urandom);
    relu_en       = 1'($urandom);
    for (int lane = 0; lane < 2; lane++) begin
      for (int s = 0; s < stalls[lane]; s++) begin
        out_ready     = 1'b0;
        capture_valid = 1'b1;
        accumulator   = {16'($urandom), 16'($urandom)};
        @(posedge clk); #1;
        checkOutput({tag, " stall out_valid"}, int'(out_valid), 1);
        checkOutput({tag, " stall out_data"}, int'($signed(out_data)), exps[lane]);
        checkOutput({tag, " stall out_index"}, int'(out_index), lane);
        checkOutput({tag, " stall capture_ready"}, int'(capture_ready), 0);
      end
      capture_valid = 1'b0;
      out_ready     = 1'b1;
      checkOutput({tag, " out_valid"}, int'(out_valid), 1);
      checkOutput({tag, " out_data"}, int'($signed(out_data)), exps[lane]);
      checkOutput({tag, " out_index"}, int'(out_index), lane);
      checkOutput({tag, " out_last"}, int'(out_last), (lane == 1) ? 1 : 0);
      checkOutput({tag, " capture_ready during drain"}, int'(capture_ready), 0);
      checkOutput({tag, " busy during drain"}, int'(busy), 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    checkOutput({tag, " out_valid after drain"}, int'(out_valid), 0);
    checkOutput({tag, " capture_ready after drain"}, int'(capture_ready), 1);
    checkOutput({tag, " busy after drain"}, int'(busy), 0);
  endtask

  // Main test sequence.
  initial begin
    int a0;
    int a1;
    int sh;
    bit relu;
    vectors[0] = '{acc0: 256,    acc1: -256,  shift: 2,  relu: 1'b0, exp0: 64,  exp1: -64};
    vectors[1] = '{acc0: 1000,   acc1: -1000, shift: 0,  relu: 1'b0, exp0: 127, exp1: -128};
    vectors[2] = '{acc0: 6,      acc1: -6,    shift: 2,  relu: 1'b0, exp0: 2,   exp1: -1};
    vectors[3] = '{acc0: 5,      acc1: 32767, shift: 1,  relu: 1'b0, exp0: 3,   exp1: 127};
    vectors[4] = '{acc0: -256,   acc1: 300,   shift: 2,  relu: 1'b1, exp0: 0,   exp1: 75};
    vectors[5] = '{acc0: -32768, acc1: 255,   shift: 15, relu: 1'b0, exp0: -1,  exp1: 0};

    capture_valid = 1'b0;
    out_ready     = 1'b0;
    accumulator   = '0;
    shift_amt     = '0;
    relu_en       = 1'b0;
    rst_n         = 1'b1;
    #1 rst_n = 1'b0;
    #10;
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset out_last", int'(out_last), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset out_index", int'(out_index), 0);
    checkOutput("reset capture_ready", int'(capture_ready), 1);
    checkOutput("reset out_data", int'($signed(out_data)), 0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vectors[i].acc0, vectors[i].acc1, vectors[i].shift, vectors[i].relu,
                    vectors[i].exp0, vectors[i].exp1, 0, 0, $sformatf("vec%0d", i));
    end

    // Backpressure on lane 0 with capture_valid and accumulator churn during the stall.
    applyStimulus(400, -77, 3, 1'b0, refQuant(400, 3, 1'b0), refQuant(-77, 3, 1'b0),
                  3, 1, "backpressure");

    // Reset asserted mid-drain after the lane 0 handshake.
    capture_valid  = 1'b1;
    accumulator[0] = 16'd100;
    accumulator[1] = 16'hFF9C;
    shift_amt      = 4'd0;
    relu_en        = 1'b0;
    @(posedge clk); #1;
    capture_valid = 1'b0;
    checkOutput("midreset lane0 data", int'($signed(out_data)), 100);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("midreset lane1 index", int'(out_index), 1);
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset out_valid", int'(out_valid), 0);
    checkOutput("midreset out_last", int'(out_last), 0);
    checkOutput("midreset busy", int'(busy), 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("midreset capture_ready after release", int'(capture_ready), 1);
    checkOutput("midreset out_index after release", int'(out_index), 0);
    applyStimulus(-20, 20, 1, 1'b0, -10, 10, 0, 0, "post-reset");

    // Randomized snapshots against the reference model.
    for (int i = 0; i < 40; i++) begin
      a0   = int'($signed(16'($urandom)));
      a1   = (i % 3 == 0) ? $urandom_range(0, 600) - 300 : int'($signed(16'($urandom)));
      sh   = $urandom_range(0, 15);
      relu = 1'($urandom);
      applyStimulus(a0, a1, sh, relu, refQuant(a0, sh, relu), refQuant(a1, sh, relu),
                    $urandom_range(0, 2), $urandom_range(0, 2), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
